// File: rtl/conv_encoder_stream.sv
// Streaming convolutional encoder with run-time rate, constraint length and
// generator polynomials. It takes one information bit per input handshake and
// emits one code symbol per output handshake. It can optionally append K-1
// zero tail bits so that the trellis terminates in state 0.
//
// Ports:
//   sys_clk, rst    clock (rising edge), asynchronous active-low reset
//   en              global enable; 0 freezes all state and handshakes
//   i_code_rate     n (2..MAX_CODE_RATE), sampled on the first bit of a frame
//   i_constr_len    K (2..MAX_CONSTRAINT_LENGTH), sampled on the first bit
//   i_gen_poly      flattened polynomials; poly j at [j*MAX_CONSTRAINT_LENGTH +: MAX_CONSTRAINT_LENGTH]
//   i_zero_term     append K-1 tail zeros after the last bit
//   i_valid/o_ready input bit handshake (i_bit, i_last)
//   o_valid/i_ready output symbol handshake (o_data, o_last)
//   o_done          one-cycle pulse when the final symbol is accepted
//   o_cfg_err       configuration invalid while idle
//   o_sym_cnt       symbols emitted in the current/last frame (saturating)
module conv_encoder_stream #(
  parameter int MAX_CODE_RATE         = 4,
  parameter int MAX_CONSTRAINT_LENGTH = 9,
  parameter int CNT_W                 = 16
) (
  input  logic                                           sys_clk,
  input  logic                                           rst,
  input  logic                                           en,
  input  logic [MAX_CODE_RATE-1:0]                       i_code_rate,
  input  logic [MAX_CONSTRAINT_LENGTH-1:0]               i_constr_len,
  input  logic [MAX_CODE_RATE*MAX_CONSTRAINT_LENGTH-1:0] i_gen_poly,
  input  logic                                           i_zero_term,
  input  logic                                           i_valid,
  output logic                                           o_ready,
  input  logic                                           i_bit,
  input  logic                                           i_last,
  output logic                                           o_valid,
  input  logic                                           i_ready,
  output logic [MAX_CODE_RATE-1:0]                       o_data,
  output logic                                           o_last,
  output logic                                           o_done,
  output logic                                           o_cfg_err,
  output logic [CNT_W-1:0]                               o_sym_cnt
);

  localparam int N  = MAX_CODE_RATE;
  localparam int K  = MAX_CONSTRAINT_LENGTH;
  localparam int TW = $clog2(K);

  typedef enum logic [1:0] {IDLE, DATA, FLUSH, DONE_WAIT} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     n_q;
  logic [K-1:0]     k_q;
  logic [N*K-1:0]   poly_q;
  logic             term_q;
  logic [K-2:0]     sr_q;
  logic [TW-1:0]    tail_q;
  logic             done_q;

  logic [N-1:0]     n_eff;
  logic [K-1:0]     k_eff;
  logic [N*K-1:0]   poly_eff;
  logic             term_eff;
  logic [K-2:0]     sr_eff;
  logic             bit_in;
  logic [K-1:0]     win;
  logic [N-1:0]     sym;
  logic             cfg_bad;
  logic             in_acc, out_acc, out_free;
  logic             load, drop, last_d, done_d;

  // While idle the live config inputs drive the first symbol of a frame;
  // afterwards the copy latched on that first bit is used.
  always_comb begin
    if (state_q == IDLE) begin
      n_eff    = i_code_rate;
      k_eff    = i_constr_len;
      poly_eff = i_gen_poly;
      term_eff = i_zero_term;
      sr_eff   = '0;
    end else begin
      n_eff    = n_q;
      k_eff    = k_q;
      poly_eff = poly_q;
      term_eff = term_q;
      sr_eff   = sr_q;
    end
  end

  assign cfg_bad = (32'(i_code_rate) < 2) || (32'(i_code_rate) > N) ||
                   (32'(i_constr_len) < 2) || (32'(i_constr_len) > K);
  assign o_cfg_err = en & (state_q == IDLE) & cfg_bad;
  assign o_ready   = en & ((state_q == IDLE) | (state_q == DATA)) &
                     (~o_valid | i_ready) & ~o_cfg_err;
  assign o_done    = done_q & en;

  assign in_acc   = i_valid & o_ready;
  assign out_acc  = en & o_valid & i_ready;
  assign out_free = ~o_valid | i_ready;

  // Tail symbols are produced by shifting in zeros.
  assign bit_in = (state_q == FLUSH) ? 1'b0 : i_bit;
  // win[0] is the current bit, win[i] the bit i positions earlier.
  assign win    = {sr_eff, bit_in};

  always_comb begin
    sym = '0;
    for (int unsigned j = 0; j < N; j++) begin
      logic acc;
      acc = 1'b0;
      for (int unsigned i = 0; i < K; i++) begin
        if (i < 32'(k_eff)) acc = acc ^ (poly_eff[j*K + i] & win[i]);
      end
      sym[j] = acc & (j < 32'(n_eff));
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    if (en) begin
      unique case (state_q)
        IDLE, DATA: begin
          if (in_acc) begin
            load   = 1'b1;
            last_d = i_last & ~term_eff;
            if (i_last)              state_d = term_eff ? FLUSH : DONE_WAIT;
            else if (state_q == IDLE) state_d = DATA;
          end else if (out_acc) begin
            drop = 1'b1;
          end
        end
        FLUSH: begin
          if (out_free) begin
            load   = 1'b1;
            last_d = (tail_q == TW'(1));
            if (tail_q == TW'(1)) state_d = DONE_WAIT;
          end
        end
        DONE_WAIT: begin
          if (out_acc) begin
            drop    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) done_q <= 1'b0;
    else      done_q <= done_d;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_last    <= 1'b0;
      o_sym_cnt <= '0;
      sr_q      <= '0;
      tail_q    <= '0;
      n_q       <= '0;
      k_q       <= '0;
      poly_q    <= '0;
      term_q    <= 1'b0;
    end else if (en) begin
      if (load) begin
        o_valid <= 1'b1;
        o_data  <= sym;
        o_last  <= last_d;
        sr_q    <= win[K-2:0];
        if (state_q == IDLE)          o_sym_cnt <= CNT_W'(1);
        else if (o_sym_cnt != '1)     o_sym_cnt <= o_sym_cnt + CNT_W'(1);
      end else if (drop) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      if (in_acc && state_q == IDLE) begin
        n_q    <= i_code_rate;
        k_q    <= i_constr_len;
        poly_q <= i_gen_poly;
        term_q <= i_zero_term;
      end
      if (in_acc && i_last)               tail_q <= TW'(k_eff - K'(1));
      else if (load && state_q == FLUSH)  tail_q <= tail_q - TW'(1);
    end
  end

endmodule

// File: tb/tb_conv_encoder_stream.sv
module tb_conv_encoder_stream;

  localparam int N  = 4;
  localparam int K  = 9;
  localparam int CW = 16;

  logic            sys_clk = 1'b0;
  logic            rst;
  logic            en;
  logic [N-1:0]    i_code_rate;
  logic [K-1:0]    i_constr_len;
  logic [N*K-1:0]  i_gen_poly;
  logic            i_zero_term;
  logic            i_valid;
  logic            o_ready;
  logic            i_bit;
  logic            i_last;
  logic            o_valid;
  logic            i_ready;
  logic [N-1:0]    o_data;
  logic            o_last;
  logic            o_done;
  logic            o_cfg_err;
  logic [CW-1:0]   o_sym_cnt;

  conv_encoder_stream #(
    .MAX_CODE_RATE         (N),
    .MAX_CONSTRAINT_LENGTH (K),
    .CNT_W                 (CW)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .en           (en),
    .i_code_rate  (i_code_rate),
    .i_constr_len (i_constr_len),
    .i_gen_poly   (i_gen_poly),
    .i_zero_term  (i_zero_term),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_bit        (i_bit),
    .i_last       (i_last),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_last       (o_last),
    .o_done       (o_done),
    .o_cfg_err    (o_cfg_err),
    .o_sym_cnt    (o_sym_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Frame configuration and stimulus
  int cfg_n;
  int cfg_k;
  int cfg_poly [N];
  int cfg_term;
  int bits_q [$];
  int exp_sym [$];
  int obs_q [$];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_cfg();
    logic [N*K-1:0] gp;
    gp = '0;
    for (int j = 0; j < N; j++) gp[j*K +: K] = K'(cfg_poly[j]);
    i_code_rate  = N'(cfg_n);
    i_constr_len = K'(cfg_k);
    i_gen_poly   = gp;
    i_zero_term  = cfg_term[0];
  endtask

  // Convolution from its definition: y_j[t] = XOR_i g_j[i] * x[t-i],
  // over the information bits followed by K-1 zeros when terminating.
  task automatic build_exp();
    int x [$];
    x = bits_q;
    if (cfg_term != 0) for (int i = 0; i < cfg_k - 1; i++) x.push_back(0);
    exp_sym.delete();
    for (int t = 0; t < x.size(); t++) begin
      int s;
      s = 0;
      for (int j = 0; j < cfg_n; j++) begin
        int p;
        p = 0;
        for (int i = 0; i < cfg_k && i <= t; i++)
          p = p ^ (((cfg_poly[j] >> i) & 1) & x[t - i]);
        s = s | (p << j);
      end
      exp_sym.push_back(s);
    end
  endtask

  // Runs one frame. stall != 0 randomizes i_valid, i_ready and en.
  // abort_after != 0 returns right before the abort_after-th symbol's
  // accepting edge, without waiting for the frame to finish.
  task automatic run_frame(input int stall, input int abort_after);
    int sent;
    int got;
    int cyc;
    int nb;
    bit done_pending;
    bit fin;
    bit hold_chk;
    int hold_val;
    sent = 0; got = 0; cyc = 0; nb = bits_q.size();
    done_pending = 0; fin = 0; hold_chk = 0; hold_val = 0;
    obs_q.delete();
    apply_cfg();
    build_exp();
    while (!fin && cyc < 3000) begin
      @(negedge sys_clk);
      cyc++;
      if (done_pending) begin
        check("done_pulse", 32'(o_done), 1);
        check("valid_after_done", 32'(o_valid), 0);
        check("sym_cnt", 32'(o_sym_cnt), exp_sym.size());
        fin = 1;
      end else begin
        check("no_early_done", 32'(o_done), 0);
      end
      if (hold_chk) check("stall_hold", 32'(o_data), hold_val);
      if (fin) break;
      en      = (stall != 0) ? ($urandom_range(0, 7) != 0) : 1'b1;
      i_ready = (stall != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      i_valid = (sent < nb) && ((stall == 0) || ($urandom_range(0, 3) != 0));
      i_bit   = (sent < nb) ? bits_q[sent][0] : 1'b0;
      i_last  = (sent == nb - 1);
      if (sent > 0) begin
        i_code_rate  = N'($urandom);
        i_constr_len = K'($urandom);
        i_gen_poly   = (N*K)'({$urandom, $urandom});
        i_zero_term  = 1'($urandom);
      end
      #1;
      if (!en) check("ready_when_disabled", 32'(o_ready), 0);
      if (o_valid && !i_ready) check("ready_when_full", 32'(o_ready), 0);
      if (i_valid && o_ready) sent++;
      hold_chk = o_valid && !(en && i_ready);
      hold_val = 32'(o_data);
      if (en && o_valid && i_ready) begin
        if (got < exp_sym.size()) begin
          check("sym_data", 32'(o_data), exp_sym[got]);
          check("sym_last", 32'(o_last), 32'(got == exp_sym.size() - 1));
        end else begin
          check("extra_symbol", got, exp_sym.size());
        end
        obs_q.push_back(32'(o_data));
        got++;
        if (o_last) done_pending = 1;
        if (abort_after != 0 && got == abort_after) break;
      end
    end
    if (abort_after == 0 && !fin) check("frame_timeout", 0, 1);
    if (abort_after != 0 && got != abort_after) check("abort_timeout", got, abort_after);
  endtask

  task automatic set_scen1(input int term);
    cfg_n = 2; cfg_k = 3; cfg_term = term;
    cfg_poly[0] = 7; cfg_poly[1] = 5; cfg_poly[2] = 0; cfg_poly[3] = 0;
    bits_q = '{1, 0, 1, 1};
  endtask

  task automatic check_scen1_literal(input string tag);
    int ref_syms [6];
    ref_syms = '{3, 1, 0, 2, 2, 3};
    check({tag, "_count"}, obs_q.size(), 6);
    for (int i = 0; i < 6 && i < obs_q.size(); i++) check(tag, obs_q[i], ref_syms[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b1; i_valid = 1'b0; i_bit = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    set_scen1(1);
    apply_cfg();
    #12;
    check("rst_valid", 32'(o_valid), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_last", 32'(o_last), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_cnt", 32'(o_sym_cnt), 0);
    @(negedge sys_clk);
    rst = 1'b1;

    // Terminated frame 1,0,1,1 with polys 7,5
    set_scen1(1);
    run_frame(0, 0);
    check_scen1_literal("scen1_term");

    // Same frame, unterminated
    set_scen1(0);
    run_frame(0, 0);
    check("scen2_count", obs_q.size(), 4);

    // Rate 3, single bit
    cfg_n = 3; cfg_k = 3; cfg_term = 0;
    cfg_poly[0] = 7; cfg_poly[1] = 7; cfg_poly[2] = 5; cfg_poly[3] = 0;
    bits_q = '{1};
    run_frame(0, 0);
    check("scen3_count", obs_q.size(), 1);
    if (obs_q.size() > 0) check("scen3_sym", obs_q[0], 7);

    // Backpressure, input gaps and enable drops
    set_scen1(1);
    run_frame(1, 0);
    check_scen1_literal("scen1_stall");

    // Invalid configuration blocks input
    @(negedge sys_clk);
    en = 1'b1; i_ready = 1'b1;
    cfg_n = 1; cfg_k = 3; apply_cfg();
    i_valid = 1'b1; i_bit = 1'b1; i_last = 1'b1;
    repeat (3) begin
      @(negedge sys_clk); #1;
      check("cfg_err_rate", 32'(o_cfg_err), 1);
      check("cfg_err_ready", 32'(o_ready), 0);
      check("cfg_err_valid", 32'(o_valid), 0);
    end
    cfg_n = 2; cfg_k = 10; apply_cfg();
    #1;
    check("cfg_err_len", 32'(o_cfg_err), 1);
    check("cfg_err_len_ready", 32'(o_ready), 0);
    @(negedge sys_clk);
    i_valid = 1'b0;
    cfg_k = 3; apply_cfg();
    #1;
    check("cfg_ok", 32'(o_cfg_err), 0);
    check("cfg_ok_ready", 32'(o_ready), 1);
    check("cfg_ok_no_output", 32'(o_valid), 0);

    // Reset in the middle of a frame, then a clean rerun
    set_scen1(1);
    run_frame(0, 2);
    @(posedge sys_clk); #1;
    rst = 1'b0; i_valid = 1'b0;
    #1;
    check("midrst_valid", 32'(o_valid), 0);
    check("midrst_data", 32'(o_data), 0);
    check("midrst_last", 32'(o_last), 0);
    check("midrst_cnt", 32'(o_sym_cnt), 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge sys_clk);
      check("midrst_no_done", 32'(o_done), 0);
      check("midrst_idle_valid", 32'(o_valid), 0);
    end
    set_scen1(1);
    run_frame(0, 0);
    check_scen1_literal("scen1_after_rst");

    // Randomized frames
    for (int f = 0; f < 14; f++) begin
      int nb;
      cfg_n = $urandom_range(2, N);
      cfg_k = $urandom_range(2, K);
      cfg_term = $urandom_range(0, 1);
      for (int j = 0; j < N; j++) cfg_poly[j] = $urandom_range(0, (1 << K) - 1);
      nb = $urandom_range(1, 16);
      bits_q.delete();
      for (int b = 0; b < nb; b++) bits_q.push_back($urandom_range(0, 1));
      run_frame(f % 3 != 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_encoder_stream.md
Name: conv_encoder_stream

Overview:
- Streaming, run-time configurable convolutional encoder; successor to the fixed-handshake encoder path inside endec.
- Takes one information bit per accepted transfer. Emits one code symbol of code_rate bits per transfer, over valid/ready handshakes on both sides.
- Optionally appends K-1 zero tail bits for trellis termination, so the Viterbi decoder starts and ends in state 0.
- Sits between the bit source and the channel/decoder model in the endec datapath.

Parameters:
MAX_CODE_RATE, 4, maximum output bits per input bit (n); o_data width
MAX_CONSTRAINT_LENGTH, 9, maximum K; generator polynomial width
CNT_W, 16, width of the symbol counter

Ports:
sys_clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  global enable; 0 freezes all state and handshakes
i_code_rate  in  MAX_CODE_RATE  n, valid range 2..MAX_CODE_RATE
i_constr_len  in  MAX_CONSTRAINT_LENGTH  K, valid range 2..MAX_CONSTRAINT_LENGTH
i_gen_poly  in  MAX_CODE_RATE*MAX_CONSTRAINT_LENGTH  flattened polynomials; poly j = bits [j*MAX_CONSTRAINT_LENGTH +: MAX_CONSTRAINT_LENGTH]
i_zero_term  in  1  1 = append K-1 tail zeros after the last bit
i_valid  in  1  input bit valid
o_ready  out  1  encoder accepts input bit
i_bit  in  1  information bit
i_last  in  1  marks last information bit of frame
o_valid  out  1  output symbol valid
i_ready  in  1  downstream accepts symbol
o_data  out  MAX_CODE_RATE  code symbol; bit j = output of poly j; bits >= n are 0
o_last  out  1  marks final symbol of frame
o_done  out  1  one-cycle pulse when the final symbol is accepted
o_cfg_err  out  1  config invalid while IDLE
o_sym_cnt  out  CNT_W  symbols emitted in the current/last frame

Behaviour:
- Reset (rst=0, async): state=IDLE, shift register=0, o_valid=0, o_data=0, o_last=0, o_done=0, o_sym_cnt=0. Latched config is cleared. A reset mid-frame abandons the frame and emits no o_done.
- en=0: no register updates. o_ready=0. o_valid, o_data and o_last hold their values. o_done is forced to 0.
- Transfers: input accepted when i_valid & o_ready; output accepted when o_valid & i_ready.
- Output register: single stage. o_ready = en & state∈{IDLE,DATA} & (!o_valid | i_ready) & !o_cfg_err.
- Latency: a bit accepted at edge t produces its symbol with o_valid=1 from edge t; visible the cycle after.
- Window definition: w[0] = current input bit, w[i] = input i bits earlier (i=1..K-1).
- Symbol arithmetic: o_data[j] = XOR over i<K of (poly_j[i] & w[i]), for j<n. Poly bits >= K are ignored.
- Shift register: K-1 bits, zero at frame start.
- States:
  - IDLE: o_cfg_err = en & (n<2 | n>MAX_CODE_RATE | K<2 | K>MAX_CONSTRAINT_LENGTH). On the first accepted bit, latch n, K, polys and i_zero_term, clear o_sym_cnt, and encode the bit. Next state is DATA, unless i_last=1 (see the last-bit rules below).
  - DATA: each accepted bit is encoded and o_sym_cnt increments.
  - Last bit in IDLE or DATA (i_last=1): with term=1 go to FLUSH, tail counter = K-1. With term=0 set o_last=1 on that symbol and go to DONE_WAIT.
  - FLUSH: o_ready=0. Whenever the output register is free (!o_valid | i_ready), the block loads the symbol for input 0 and decrements the tail counter. o_last=1 on the final tail symbol, then go to DONE_WAIT.
  - DONE_WAIT: o_ready=0. When the o_last symbol is accepted: pulse o_done for 1 cycle, clear o_valid, go to IDLE. o_sym_cnt holds its final value.
- Config inputs are ignored outside IDLE. Changes mid-frame have no effect.
- Backpressure: o_data and o_last stay stable while o_valid & !i_ready. No symbol is dropped or duplicated.
- Simultaneous events: an output accept and the next input accept in the same cycle are both honoured; throughput is 1 symbol/cycle.
- o_sym_cnt saturates at 2^CNT_W-1.

Test Plan:
- n=2, K=3, polys 7,5, term=1, input 1,0,1,1 (i_last on the 4th bit), i_ready=1 -> o_data = 2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11. o_last and o_done on the 6th symbol; o_sym_cnt=6.
- Same frame with term=0 -> 4 symbols, 2'b11, 2'b01, 2'b00, 2'b10. o_last on the 4th; o_sym_cnt=4.
- n=3, K=3, polys 7,7,5, term=0, single bit 1 with i_last -> one symbol o_data=4'b0111, o_last=1, o_done pulse.
- Rerun the first scenario with i_ready toggling 1,0,0,1,... and i_valid gaps -> identical symbol sequence; o_data held stable during stalls; o_ready low whenever the output register is full and not draining.
- i_code_rate=1 (or i_constr_len=10) in IDLE -> o_cfg_err=1, o_ready=0, no output. Fix config -> o_cfg_err=0 and normal operation.
- Assert rst low for 1 cycle after the 2nd symbol of the first scenario -> all outputs 0 immediately, no o_done. A new frame then encodes from the zero state, matching the first scenario.
